// File: rtl/timer_apb_nch.sv
// -----------------------------------------------------------------------------
// timer_apb_nch
//
// Multi-channel APB timer. NUM_CH independent CNT_W-bit up/down counters, each
// with its own 4-bit prescaler, TDR/TCR/TSR/TCNT registers and interrupt line.
// Channel n occupies byte addresses 4n..4n+3:
//   +0 TDR  reload/data (RW)
//   +1 TCR  control (RW): [7] load, [5] dir, [4] en, [3] ovf_ie, [2] udf_ie, [1:0] cks
//   +2 TSR  status (W1C): [1] underflow, [0] overflow
//   +3 TCNT live counter (RO, writes ignored without error)
//
// Build option:
//   TIMER_AUTO_RELOAD_EN  when defined, overflow/underflow reloads TDR into the
//                         counter instead of wrapping.
//
// Ports:
//   pclk     clock, all logic on the rising edge
//   preset   synchronous active-high reset
//   psel, penable, pwrite, paddr, pwdata   APB request
//   prdata   read data (0 when not selected or unmapped)
//   pready   always 1
//   pslverr  1 during an access phase to an unmapped address
//   irq      per-channel registered interrupt
// -----------------------------------------------------------------------------
module timer_apb_nch #(
    parameter int CNT_W  = 8,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [CNT_W-1:0]  pwdata,
    output logic [CNT_W-1:0]  prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq
);

    logic [31:0]      paddr_ext;
    logic             mapped;
    logic             wr_access;
    logic [NUM_CH-1:0] ch_sel;
    logic [CNT_W-1:0] ch_rdata [NUM_CH];

    assign paddr_ext = 32'(paddr);
    assign mapped    = (paddr_ext < 32'(4 * NUM_CH));
    assign wr_access = psel & penable & pwrite;
    assign pready    = 1'b1;
    assign pslverr   = psel & penable & ~mapped;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] tdr_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [6:0]       tcr_reg;    // {load, dir, en, ovf_ie, udf_ie, cks}; bit 6 of TCR is not stored
            logic [1:0]       tsr_reg;
            logic [3:0]       presc_reg;
            logic             irq_reg;
            logic             load, dir, en, ovf_ie, udf_ie;
            logic [1:0]       cks;
            logic [3:0]       presc_mask;
            logic             tick, step, ovf_set, udf_set;
            logic             wr_tdr, wr_tcr, wr_tsr;
            logic [CNT_W-1:0] rdata;

            // Only channel indices below NUM_CH exist, so a match implies a mapped address.
            assign ch_sel[gi] = (paddr_ext[31:2] == 30'(gi));
            assign wr_tdr     = wr_access & ch_sel[gi] & (paddr_ext[1:0] == 2'd0);
            assign wr_tcr     = wr_access & ch_sel[gi] & (paddr_ext[1:0] == 2'd1);
            assign wr_tsr     = wr_access & ch_sel[gi] & (paddr_ext[1:0] == 2'd2);

            assign {load, dir, en, ovf_ie, udf_ie, cks} = tcr_reg;

            always_comb begin
                case (cks)
                    2'd0:    presc_mask = 4'b0001;
                    2'd1:    presc_mask = 4'b0011;
                    2'd2:    presc_mask = 4'b0111;
                    default: presc_mask = 4'b1111;
                endcase
            end

            assign tick    = ((presc_reg & presc_mask) == presc_mask);
            assign step    = en & ~load & tick;
            assign ovf_set = step & ~dir & (cnt_reg == '1);
            assign udf_set = step &  dir & (cnt_reg == '0);

            always_comb begin
                cnt_next = cnt_reg;
                if (load) begin
                    cnt_next = tdr_reg;
                end else if (step) begin
                    // Plain modular arithmetic gives the wrap (max->0, 0->max).
                    cnt_next = dir ? (cnt_reg - CNT_W'(1)) : (cnt_reg + CNT_W'(1));
`ifdef TIMER_AUTO_RELOAD_EN
                    if (ovf_set || udf_set)
                        cnt_next = tdr_reg;
`endif
                end
            end

            always_ff @(posedge pclk) begin
                if (preset) begin
                    tdr_reg   <= '0;
                    tcr_reg   <= '0;
                    tsr_reg   <= '0;
                    presc_reg <= '0;
                    cnt_reg   <= '0;
                    irq_reg   <= 1'b0;
                end else begin
                    if (wr_tdr)
                        tdr_reg <= pwdata;
                    if (wr_tcr)
                        tcr_reg <= {pwdata[7], pwdata[5:0]};
                    // Set terms are OR-ed after the clear so a same-cycle set wins.
                    tsr_reg   <= (tsr_reg & ~(wr_tsr ? pwdata[1:0] : 2'b00)) | {udf_set, ovf_set};
                    presc_reg <= (en && !load) ? (presc_reg + 4'd1) : 4'd0;
                    cnt_reg   <= cnt_next;
                    irq_reg   <= |(tsr_reg & {udf_ie, ovf_ie});
                end
            end

            always_comb begin
                case (paddr_ext[1:0])
                    2'd0:    rdata = tdr_reg;
                    2'd1:    rdata = CNT_W'({tcr_reg[6], 1'b0, tcr_reg[5:0]});
                    2'd2:    rdata = CNT_W'(tsr_reg);
                    default: rdata = cnt_reg;
                endcase
            end

            assign ch_rdata[gi] = rdata;
            assign irq[gi]      = irq_reg;
        end
    endgenerate

    always_comb begin
        prdata = '0;
        if (psel && mapped) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel[i])
                    prdata = ch_rdata[i];
            end
        end
    end

endmodule

// File: tb/tb_timer_apb_nch.sv
// -----------------------------------------------------------------------------
// tb_timer_apb_nch
//
// Directed bench for timer_apb_nch. Two instances: dut8 (CNT_W=8, NUM_CH=4)
// and dut16 (CNT_W=16, NUM_CH=4). They share the bus and reset but have
// separate psel lines. Each scenario task drives its own stimulus and compares
// against hand-computed values; times are counted in posedges after the commit
// edge of the enabling write.
// -----------------------------------------------------------------------------
module tb_timer_apb_nch;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel8 = 1'b0;
    logic        psel16 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [15:0] pwdata = '0;
    logic [7:0]  prdata8;
    logic [15:0] prdata16;
    logic        pready8, pready16;
    logic        pslverr8, pslverr16;
    logic [3:0]  irq8, irq16;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] rd;
    logic        err;

`ifdef TIMER_AUTO_RELOAD_EN
    localparam logic [15:0] OVF8_CNT  = 16'h00F0;
    localparam logic [15:0] UDF8_CNT  = 16'h0005;
    localparam logic [15:0] OVF16_CNT = 16'hFFF0;
    localparam logic [15:0] UDF16_CNT = 16'h0001;
`else
    localparam logic [15:0] OVF8_CNT  = 16'h0000;
    localparam logic [15:0] UDF8_CNT  = 16'h00FF;
    localparam logic [15:0] OVF16_CNT = 16'h0000;
    localparam logic [15:0] UDF16_CNT = 16'hFFFF;
`endif

    always #5 pclk = ~pclk;

    timer_apb_nch #(.CNT_W(8), .NUM_CH(4), .ADDR_W(8)) dut8 (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel8),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata[7:0]),
        .prdata  (prdata8),
        .pready  (pready8),
        .pslverr (pslverr8),
        .irq     (irq8)
    );

    timer_apb_nch #(.CNT_W(16), .NUM_CH(4), .ADDR_W(8)) dut16 (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel16),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata16),
        .pready  (pready16),
        .pslverr (pslverr16),
        .irq     (irq16)
    );

    // Full two-phase APB write. Called just after a posedge; returns 1 ns after
    // the commit edge. err is pslverr sampled in the access phase.
    task automatic apb_write(input bit d16, input logic [7:0] addr,
                             input logic [15:0] data, output logic werr);
        psel8   = !d16;
        psel16  = d16;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        werr = d16 ? pslverr16 : pslverr8;
        @(posedge pclk); #1;
        psel8   = 1'b0;
        psel16  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        $display("write %s addr=%02h data=%04h pslverr=%b", d16 ? "dut16" : "dut8 ", addr, data, werr);
    endtask

    // Zero-time (1 ns) read: prdata is combinational in the access phase.
    task automatic apb_peek(input bit d16, input logic [7:0] addr,
                            output logic [15:0] data, output logic rerr);
        psel8   = !d16;
        psel16  = d16;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = addr;
        #1;
        data = d16 ? prdata16 : {8'h00, prdata8};
        rerr = d16 ? pslverr16 : pslverr8;
        psel8   = 1'b0;
        psel16  = 1'b0;
        penable = 1'b0;
        $display("read  %s addr=%02h data=%04h pslverr=%b", d16 ? "dut16" : "dut8 ", addr, data, rerr);
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b0;
        n_checks++;
        if (pready8 !== 1'b1 || pready16 !== 1'b1 || pslverr8 !== 1'b0 || prdata8 !== 8'h00 || prdata16 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got pready=%b/%b pslverr=%b prdata=%h/%h, expected 1/1 0 00/0000",
                     pready8, pready16, pslverr8, prdata8, prdata16);
        end
        for (int a = 0; a < 16; a++) begin
            apb_peek(1'b0, 8'(a), rd, err);
            n_checks++;
            if (rd !== 16'h0000 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_reg addr=%0d: got %h err=%b, expected 0000 err=0", a, rd, err);
            end
        end
        n_checks++;
        if (irq8 !== 4'b0000 || irq16 !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_irq: got %b/%b, expected 0000/0000", irq8, irq16);
        end
    endtask

    task automatic test_overflow();
        apb_write(1'b0, 8'h00, 16'h00F0, err);
        apb_write(1'b0, 8'h01, 16'h0080, err);
        apb_write(1'b0, 8'h01, 16'h0010, err);        // commit edge E0
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_wr_err: got pslverr=%b, expected 0", err);
        end
        repeat (31) @(posedge pclk);
        #1;                                           // E31
        apb_peek(1'b0, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL ovf_tsr_early: got %h, expected 0000", rd);
        end
        apb_peek(1'b0, 8'h03, rd, err);
        n_checks++;
        if (rd !== 16'h00FF) begin
            n_fail++;
            $display("FAIL ovf_cnt_max: got %h, expected 00ff", rd);
        end
        @(posedge pclk); #1;                          // E32
        apb_peek(1'b0, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0001) begin
            n_fail++;
            $display("FAIL ovf_tsr: got %h, expected 0001", rd);
        end
        apb_peek(1'b0, 8'h03, rd, err);
        n_checks++;
        if (rd !== OVF8_CNT) begin
            n_fail++;
            $display("FAIL ovf_cnt_wrap: got %h, expected %h", rd, OVF8_CNT);
        end
        apb_peek(1'b0, 8'h01, rd, err);
        n_checks++;
        if (rd !== 16'h0010 || irq8 !== 4'b0000) begin
            n_fail++;
            $display("FAIL ovf_tcr_irq: got tcr=%h irq=%b, expected 0010 0000", rd, irq8);
        end
        apb_write(1'b0, 8'h01, 16'h0000, err);
    endtask

    task automatic test_w1c();
        // Underflow from 0 to add TSR0[1] to the pending TSR0[0].
        apb_write(1'b0, 8'h00, 16'h0000, err);
        apb_write(1'b0, 8'h01, 16'h0080, err);
        apb_write(1'b0, 8'h01, 16'h0030, err);
        repeat (3) @(posedge pclk);
        #1;
        apb_write(1'b0, 8'h01, 16'h0000, err);
        apb_peek(1'b0, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0003) begin
            n_fail++;
            $display("FAIL w1c_both_set: got %h, expected 0003", rd);
        end
        apb_write(1'b0, 8'h02, 16'h0001, err);
        apb_peek(1'b0, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0002) begin
            n_fail++;
            $display("FAIL w1c_clear: got %h, expected 0002", rd);
        end
        // Overflow lands 4 edges after the enable commit; time the clear to that edge.
        apb_write(1'b0, 8'h00, 16'h00FE, err);
        apb_write(1'b0, 8'h01, 16'h0080, err);
        apb_write(1'b0, 8'h01, 16'h0010, err);        // commit C
        repeat (2) @(posedge pclk);
        #1;
        apb_write(1'b0, 8'h02, 16'h0001, err);        // commit C+4
        apb_peek(1'b0, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0003) begin
            n_fail++;
            $display("FAIL w1c_set_wins: got %h, expected 0003", rd);
        end
        apb_write(1'b0, 8'h01, 16'h0000, err);
        apb_write(1'b0, 8'h02, 16'h0003, err);
        apb_peek(1'b0, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL w1c_clear_all: got %h, expected 0000", rd);
        end
    endtask

    task automatic test_underflow();
        apb_write(1'b0, 8'h08, 16'h0005, err);
        apb_write(1'b0, 8'h09, 16'h0080, err);
        apb_write(1'b0, 8'h09, 16'h0035, err);        // commit E0
        repeat (23) @(posedge pclk);
        #1;                                           // E23
        apb_peek(1'b0, 8'h0A, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL udf_tsr_early: got %h, expected 0000", rd);
        end
        apb_peek(1'b0, 8'h0B, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL udf_cnt_zero: got %h, expected 0000", rd);
        end
        @(posedge pclk); #1;                          // E24
        apb_peek(1'b0, 8'h0A, rd, err);
        n_checks++;
        if (rd !== 16'h0002) begin
            n_fail++;
            $display("FAIL udf_tsr: got %h, expected 0002", rd);
        end
        apb_peek(1'b0, 8'h0B, rd, err);
        n_checks++;
        if (rd !== UDF8_CNT) begin
            n_fail++;
            $display("FAIL udf_cnt_wrap: got %h, expected %h", rd, UDF8_CNT);
        end
        n_checks++;
        if (irq8 !== 4'b0000) begin
            n_fail++;
            $display("FAIL udf_irq_latency: got %b, expected 0000", irq8);
        end
        @(posedge pclk); #1;                          // E25
        n_checks++;
        if (irq8 !== 4'b0100) begin
            n_fail++;
            $display("FAIL udf_irq: got %b, expected 0100", irq8);
        end
        apb_write(1'b0, 8'h0A, 16'h0002, err);        // clear commit X
        n_checks++;
        if (irq8 !== 4'b0100) begin
            n_fail++;
            $display("FAIL udf_irq_hold: got %b, expected 0100", irq8);
        end
        @(posedge pclk); #1;
        n_checks++;
        if (irq8 !== 4'b0000) begin
            n_fail++;
            $display("FAIL udf_irq_clear: got %b, expected 0000", irq8);
        end
        apb_write(1'b0, 8'h09, 16'h0000, err);
    endtask

    task automatic test_reset_midcount();
        apb_write(1'b0, 8'h04, 16'h0000, err);
        apb_write(1'b0, 8'h05, 16'h0080, err);
        apb_write(1'b0, 8'h05, 16'h0034, err);        // ch1 underflows 2 edges later
        apb_write(1'b0, 8'h0C, 16'h00AA, err);
        apb_write(1'b0, 8'h0D, 16'h0081, err);
        apb_write(1'b0, 8'h00, 16'h00F0, err);
        apb_write(1'b0, 8'h01, 16'h0080, err);
        apb_write(1'b0, 8'h01, 16'h0018, err);        // commit E0
        repeat (16) @(posedge pclk);
        #1;
        apb_peek(1'b0, 8'h03, rd, err);
        n_checks++;
        if (rd !== 16'h00F8) begin
            n_fail++;
            $display("FAIL mid_cnt_before: got %h, expected 00f8", rd);
        end
        n_checks++;
        if (irq8 !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_irq_before: got %b, expected 0010", irq8);
        end
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            apb_peek(1'b0, 8'(a), rd, err);
            n_checks++;
            if (rd !== 16'h0000) begin
                n_fail++;
                $display("FAIL mid_reset_reg addr=%0d: got %h, expected 0000", a, rd);
            end
        end
        n_checks++;
        if (irq8 !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_irq: got %b, expected 0000", irq8);
        end
        repeat (8) @(posedge pclk);
        #1;
        apb_peek(1'b0, 8'h03, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_no_resume: got %h, expected 0000", rd);
        end
    endtask

    task automatic test_unmapped();
        apb_write(1'b0, 8'h10, 16'h005A, err);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL unmap_wr_err: got pslverr=%b, expected 1", err);
        end
        apb_peek(1'b0, 8'h10, rd, err);
        n_checks++;
        if (rd !== 16'h0000 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL unmap_rd: got %h err=%b, expected 0000 err=1", rd, err);
        end
        apb_peek(1'b0, 8'hFF, rd, err);
        n_checks++;
        if (rd !== 16'h0000 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL unmap_rd_top: got %h err=%b, expected 0000 err=1", rd, err);
        end
        for (int a = 0; a < 16; a++) begin
            apb_peek(1'b0, 8'(a), rd, err);
            n_checks++;
            if (rd !== 16'h0000 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL unmap_no_change addr=%0d: got %h err=%b, expected 0000 err=0", a, rd, err);
            end
        end
    endtask

    task automatic test_regs();
        apb_write(1'b0, 8'h05, 16'h00FF, err);
        apb_peek(1'b0, 8'h05, rd, err);
        n_checks++;
        if (rd !== 16'h00BF) begin
            n_fail++;
            $display("FAIL tcr_reserved: got %h, expected 00bf", rd);
        end
        apb_write(1'b0, 8'h07, 16'h0077, err);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL tcnt_wr_err: got pslverr=%b, expected 0", err);
        end
        apb_peek(1'b0, 8'h07, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL tcnt_wr_ignored: got %h, expected 0000", rd);
        end
        apb_write(1'b0, 8'h05, 16'h0000, err);
        apb_write(1'b0, 8'h04, 16'h0033, err);
        @(posedge pclk); #1;
        apb_peek(1'b0, 8'h07, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL tdr_no_effect: got %h, expected 0000", rd);
        end
        apb_write(1'b0, 8'h05, 16'h0080, err);
        @(posedge pclk); #1;
        apb_peek(1'b0, 8'h07, rd, err);
        n_checks++;
        if (rd !== 16'h0033) begin
            n_fail++;
            $display("FAIL load_tdr: got %h, expected 0033", rd);
        end
        apb_write(1'b0, 8'h05, 16'h0000, err);
    endtask

    task automatic test_independence();
        apb_write(1'b1, 8'h00, 16'hFFF0, err);
        apb_write(1'b1, 8'h01, 16'h0080, err);
        apb_write(1'b1, 8'h04, 16'h0001, err);
        apb_write(1'b1, 8'h05, 16'h0080, err);
        apb_write(1'b1, 8'h01, 16'hFF10, err);        // commit A; reserved high bits dropped
        apb_write(1'b1, 8'h05, 16'h0033, err);        // commit A+2
        repeat (29) @(posedge pclk);
        #1;                                           // A+31
        apb_peek(1'b1, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL ind_tsr0_early: got %h, expected 0000", rd);
        end
        @(posedge pclk); #1;                          // A+32
        apb_peek(1'b1, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0001) begin
            n_fail++;
            $display("FAIL ind_tsr0: got %h, expected 0001", rd);
        end
        apb_peek(1'b1, 8'h03, rd, err);
        n_checks++;
        if (rd !== OVF16_CNT) begin
            n_fail++;
            $display("FAIL ind_cnt0: got %h, expected %h", rd, OVF16_CNT);
        end
        @(posedge pclk); #1;                          // A+33
        apb_peek(1'b1, 8'h06, rd, err);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL ind_tsr1_early: got %h, expected 0000", rd);
        end
        @(posedge pclk); #1;                          // A+34
        apb_peek(1'b1, 8'h06, rd, err);
        n_checks++;
        if (rd !== 16'h0002) begin
            n_fail++;
            $display("FAIL ind_tsr1: got %h, expected 0002", rd);
        end
        apb_peek(1'b1, 8'h07, rd, err);
        n_checks++;
        if (rd !== UDF16_CNT) begin
            n_fail++;
            $display("FAIL ind_cnt1: got %h, expected %h", rd, UDF16_CNT);
        end
        apb_peek(1'b1, 8'h02, rd, err);
        n_checks++;
        if (rd !== 16'h0001) begin
            n_fail++;
            $display("FAIL ind_tsr0_untouched: got %h, expected 0001", rd);
        end
        apb_peek(1'b1, 8'h01, rd, err);
        n_checks++;
        if (rd !== 16'h0010 || irq16 !== 4'b0000) begin
            n_fail++;
            $display("FAIL ind_tcr0_irq: got tcr=%h irq=%b, expected 0010 0000", rd, irq16);
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_w1c();
        test_underflow();
        test_reset_midcount();
        test_unmapped();
        test_regs();
        test_independence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
